// File: rtl/red_and_stream.sv
// red_and_stream
//
// Purpose:
//   Streaming AND reduction over a multi-beat packet. Every bit of every
//   accepted beat is AND-reduced. One registered result is produced per
//   packet: the reduced bit, the (saturating) beat count, the index of the
//   first beat that held a 0 bit, and an overflow flag for packets longer
//   than MaxBeats.
//
// Parameters:
//   width     beat width in bits (>= 1)
//   MaxBeats  beats per packet counted exactly (>= 1)
//   CntWidth  derived counter/index width, floor(log2(MaxBeats))+1
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous reset, active-high
//   clear_i      synchronous abort of a partial packet or pending result
//   in_data_i    beat data
//   in_last_i    final beat of the packet
//   in_valid_i   beat valid
//   in_ready_o   high while accumulating; beat taken on valid & ready
//   z_o          AND of all bits of all beats
//   beats_o      beats in packet, saturating at MaxBeats
//   zero_idx_o   0-based index of first beat containing a 0 (0 if z_o=1)
//   ovf_o        packet had more than MaxBeats beats
//   out_valid_o  result valid
//   out_ready_i  result consumed on out_valid & out_ready
module red_and_stream #(
  parameter  int width    = 8,
  parameter  int MaxBeats = 16,
  localparam int CntWidth = $clog2(MaxBeats + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [width-1:0]    in_data_i,
  input  logic                in_last_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic                z_o,
  output logic [CntWidth-1:0] beats_o,
  output logic [CntWidth-1:0] zero_idx_o,
  output logic                ovf_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxBeats);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Saturating increment: the counter parks at MaxBeats instead of wrapping.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
    if (c == CntMax) begin
      return c;
    end
    return c + CntWidth'(1);
  endfunction

  // Accumulator stage (p0) and registered result stage (p1)
  logic                acc_p0;
  logic [CntWidth-1:0] cnt_p0;
  logic                zero_seen_p0;
  logic [CntWidth-1:0] zidx_p0;
  logic                ovf_p0;

  logic                z_p1;
  logic [CntWidth-1:0] beats_p1;
  logic [CntWidth-1:0] zidx_p1;
  logic                ovf_p1;

  logic                red;
  logic                beat_fire;
  logic                last_fire;
  logic                res_fire;

  logic                acc_nxt;
  logic [CntWidth-1:0] cnt_nxt;
  logic                zero_seen_nxt;
  logic [CntWidth-1:0] zidx_nxt;
  logic                ovf_nxt;

  assign red       = &in_data_i;
  assign beat_fire = in_valid_i & (state == ACC);
  // clear_i wins over a same-cycle last beat or result handshake.
  assign last_fire = beat_fire & in_last_i & ~clear_i;
  assign res_fire  = (state == OUT) & out_ready_i;

  // Values after folding in the current beat; these also feed the result
  // latch so the last beat is included in the reported result.
  always_comb begin
    acc_nxt       = acc_p0 & red;
    cnt_nxt       = sat_inc(cnt_p0);
    ovf_nxt       = ovf_p0 | (cnt_p0 == CntMax);
    zero_seen_nxt = zero_seen_p0 | ~red;
    zidx_nxt      = zidx_p0;
    // Only the first zero-bearing beat is recorded; cnt_p0 is already
    // saturated so the index saturates with it.
    if (!red && !zero_seen_p0) begin
      zidx_nxt = cnt_p0;
    end
  end

  // Control: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (last_fire) state_nxt = OUT;
        OUT:     if (res_fire)  state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  // Stage p0: per-packet accumulation
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_p0       <= 1'b1;
      cnt_p0       <= '0;
      zero_seen_p0 <= 1'b0;
      zidx_p0      <= '0;
      ovf_p0       <= 1'b0;
    end else if (clear_i || res_fire) begin
      acc_p0       <= 1'b1;
      cnt_p0       <= '0;
      zero_seen_p0 <= 1'b0;
      zidx_p0      <= '0;
      ovf_p0       <= 1'b0;
    end else if (beat_fire) begin
      acc_p0       <= acc_nxt;
      cnt_p0       <= cnt_nxt;
      zero_seen_p0 <= zero_seen_nxt;
      zidx_p0      <= zidx_nxt;
      ovf_p0       <= ovf_nxt;
    end
  end

  // Stage p1: result registers, loaded on the last-beat handshake and held
  // afterwards (including across the result handshake)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      z_p1     <= 1'b1;
      beats_p1 <= '0;
      zidx_p1  <= '0;
      ovf_p1   <= 1'b0;
    end else if (last_fire) begin
      z_p1     <= acc_nxt;
      beats_p1 <= cnt_nxt;
      zidx_p1  <= zidx_nxt;
      ovf_p1   <= ovf_nxt;
    end
  end

  assign in_ready_o  = (state == ACC);
  assign out_valid_o = (state == OUT);
  assign z_o         = z_p1;
  assign beats_o     = beats_p1;
  assign zero_idx_o  = zidx_p1;
  assign ovf_o       = ovf_p1;

endmodule
